earom_ctrl: RTL and testbench

EAROM_CTRL -- requirements
Module: earom_ctrl

---
 rtl/earom_pkg.sv | 27 ++
 rtl/earom_mem.sv | 30 +++
 rtl/earom_ctrl.sv | 165 ++++++++++++++++
 tb/tb_earom_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/earom_pkg.sv
// earom_pkg -- shared definitions for the EAROM controller.
//   cmd_e    : CPU command encoding taken from {c1,c2}
//   state_e  : controller state
//   CNT_W    : width of the program-cycle counter (PROG_CYCLES <= 255)
package earom_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_ERASE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROG = 2'd1,
    HOST = 2'd2
  } state_e;

  localparam int CNT_W = 8;

  // Commands that occupy the array for a full program cycle.
  function automatic logic is_prog_cmd(input cmd_e c);
    return (c == CMD_WRITE) || (c == CMD_ERASE);
  endfunction

endpackage

// File: rtl/earom_mem.sv
// earom_mem -- single-port synchronous RAM backing the EAROM cells.
//   clk    : clock
//   we     : write enable, mem[addr] <= wdata on the rising edge
//   re     : read enable, rdata <= mem[addr] on the rising edge
//   addr   : cell address (shared by read and write, one access per cycle)
//   wdata  : write data
//   rdata  : registered read data, holds until the next read
// Contents are deliberately not reset: the array models non-volatile cells.
module earom_mem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/earom_ctrl.sv
// earom_ctrl -- EAROM emulation: CPU command port plus a host save/load port.
//   clk, reset_n              : clock, async active-low reset
//   cpu_a/cpu_din/cpu_dout    : CPU address, write data, read data (holds)
//   cpu_c1/cpu_c2/cpu_cs1     : command lines; {c1,c2} selects the command
//   cpu_strobe                : one-cycle command qualifier
//   cpu_busy                  : a write/erase program cycle is running
//   host_a/host_din/host_dout : host address, write data, read data
//   host_rd/host_we/host_ack  : level requests held until the one-cycle ack
//   dirty/dirty_clr           : set by CPU commits, cleared by the host
// A write or erase keeps the array busy for PROG_CYCLES cycles and commits
// on the last of them, so a reset during that window leaves the cell intact.
module earom_ctrl
  import earom_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int PROG_CYCLES = 16,
  parameter int ERASE_VALUE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_c1,
  input  logic              cpu_c2,
  input  logic              cpu_cs1,
  input  logic              cpu_strobe,
  output logic              cpu_busy,
  input  logic [ADDR_W-1:0] host_a,
  input  logic [DATA_W-1:0] host_din,
  output logic [DATA_W-1:0] host_dout,
  input  logic              host_rd,
  input  logic              host_we,
  output logic              host_ack,
  output logic              dirty,
  input  logic              dirty_clr
);

  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PROG_CYCLES - 1);
  localparam logic [DATA_W-1:0] ERASE_D  = DATA_W'(ERASE_VALUE);

  cmd_e              cmd;
  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_d;
  logic              lat_erase;

  logic              cpu_sel;    // strobe addressed to us, whatever the state
  logic              cpu_go;     // strobe actually accepted
  logic              cpu_rd_go;
  logic              cpu_pr_go;
  logic              host_go;
  logic              commit;

  logic              cpu_rd_d;   // cpu_dout follows the RAM this cycle
  logic              host_rd_d;  // host_dout follows the RAM this cycle
  logic [DATA_W-1:0] cpu_dout_q;
  logic [DATA_W-1:0] host_dout_q;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign cmd       = cmd_e'({cpu_c1, cpu_c2});
  assign cpu_sel   = cpu_strobe & cpu_cs1;
  // Only a running program cycle blocks the CPU; the one-cycle HOST ack
  // state leaves the array free, so CPU commands are taken there too.
  assign cpu_go    = cpu_sel & (state != PROG);
  assign cpu_rd_go = cpu_go & (cmd == CMD_READ);
  assign cpu_pr_go = cpu_go & is_prog_cmd(cmd);
  // Any CPU strobe with cs1 (even a NOP) takes priority over the host.
  assign host_go   = (state == IDLE) & ~cpu_sel & (host_rd | host_we);
  assign commit    = (state == PROG) & (cnt == '0);
  assign cpu_busy  = (state == PROG);

  // Single RAM port: the cases below are mutually exclusive by construction
  // (commit only in PROG, CPU read only outside PROG, host only without CPU).
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = cpu_a;
    mem_wdata = host_din;
    if (commit) begin
      mem_we    = 1'b1;
      mem_addr  = lat_a;
      mem_wdata = lat_erase ? ERASE_D : lat_d;
    end else if (cpu_rd_go) begin
      mem_re = 1'b1;
    end else if (host_go) begin
      mem_addr = host_a;
      mem_we   = host_we;   // write wins when both are requested
      mem_re   = ~host_we;
    end
  end

  earom_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // The RAM output register is shared, so each port keeps its own copy of
  // the last value it was given and only looks at the RAM right after its
  // own read.
  assign cpu_dout  = cpu_rd_d  ? mem_rdata : cpu_dout_q;
  assign host_dout = host_rd_d ? mem_rdata : host_dout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_a       <= '0;
      lat_d       <= '0;
      lat_erase   <= 1'b0;
      cpu_rd_d    <= 1'b0;
      host_rd_d   <= 1'b0;
      cpu_dout_q  <= '0;
      host_dout_q <= '0;
      host_ack    <= 1'b0;
      dirty       <= 1'b0;
    end else begin
      cpu_rd_d    <= cpu_rd_go;
      host_rd_d   <= host_go & ~host_we;
      host_ack    <= host_go;
      cpu_dout_q  <= cpu_dout;
      host_dout_q <= host_dout;

      // Commit beats a simultaneous clear so no change is ever lost.
      if (commit)         dirty <= 1'b1;
      else if (dirty_clr) dirty <= 1'b0;

      case (state)
        IDLE, HOST: begin
          if (cpu_pr_go) begin
            state     <= PROG;
            cnt       <= CNT_LOAD;
            lat_a     <= cpu_a;
            lat_d     <= cpu_din;
            lat_erase <= (cmd == CMD_ERASE);
          end else if (host_go) begin
            state <= HOST;
          end else begin
            state <= IDLE;
          end
        end
        PROG: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_earom_ctrl.sv
// tb_earom_ctrl -- randomized scoreboard bench for earom_ctrl.
// The stimulus process keeps an array image of the cells and pushes the
// expected CPU read data / host acks into queues; a negedge monitor pops and
// compares them, and also checks cpu_busy against the expected busy window
// and that cpu_dout holds between reads.
module tb_earom_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int PC    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cpu_a = '0, host_a = '0;
  logic [DW-1:0] cpu_din = '0, host_din = '0;
  logic          cpu_c1 = 1'b1, cpu_c2 = 1'b1, cpu_cs1 = 1'b0, cpu_strobe = 1'b0;
  logic          host_rd = 1'b0, host_we = 1'b0, dirty_clr = 1'b0;
  logic [DW-1:0] cpu_dout, host_dout;
  logic          cpu_busy, host_ack, dirty;

  earom_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .PROG_CYCLES(PC), .ERASE_VALUE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_c1(cpu_c1), .cpu_c2(cpu_c2), .cpu_cs1(cpu_cs1),
    .cpu_strobe(cpu_strobe), .cpu_busy(cpu_busy),
    .host_a(host_a), .host_din(host_din), .host_dout(host_dout),
    .host_rd(host_rd), .host_we(host_we), .host_ack(host_ack),
    .dirty(dirty), .dirty_clr(dirty_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int due; logic [DW-1:0] val; } cpu_exp_t;
  typedef struct { int due; bit rd; logic [DW-1:0] val; } host_exp_t;

  cpu_exp_t      cpu_q[$];
  host_exp_t     host_q[$];
  logic [DW-1:0] model [DEPTH];
  int            busy_lo = -1, busy_hi = -2;
  bit            mon_en = 1'b0;
  bit            exp_dirty = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [DW-1:0] exp_dout = '0;
  cpu_exp_t      mc;
  host_exp_t     mh;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_dout = '0;
      cpu_q.delete();
    end else if (mon_en) begin
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        mc = cpu_q.pop_front();
        exp_dout = mc.val;
      end
      chk("cpu_dout", 32'(cpu_dout), 32'(exp_dout));
      chk("cpu_busy", 32'(cpu_busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (host_ack) begin
        if (host_q.size() == 0) begin
          chk("host_ack_unexpected", 32'(host_ack), 0);
        end else begin
          mh = host_q.pop_front();
          chk("host_ack_cycle", 32'(cyc), 32'(mh.due));
          if (mh.rd) chk("host_dout", 32'(host_dout), 32'(mh.val));
        end
      end else if (host_q.size() > 0 && host_q[0].due < cyc) begin
        mh = host_q.pop_front();
        chk("host_ack_missing", 32'(host_ack), 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    cpu_exp_t c;
    c.due = cyc + 1;
    c.val = model[a];
    cpu_q.push_back(c);
    cpu_a = a; {cpu_c1, cpu_c2} = 2'b10; cpu_cs1 = 1'b1; cpu_strobe = 1'b1;
    tick();
    cpu_strobe = 1'b0;
  endtask

  // Strobe that must have no effect (NOP, or cs1 low with any command).
  task automatic cpu_noeffect(input bit cs1);
    cpu_a = AW'($urandom); cpu_din = DW'($urandom);
    {cpu_c1, cpu_c2} = cs1 ? 2'b11 : 2'($urandom_range(0, 3));
    cpu_cs1 = cs1; cpu_strobe = 1'b1;
    tick();
    cpu_strobe = 1'b0; cpu_cs1 = 1'b1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit erase, input bit clr_at_commit);
    int k;
    k = cyc;
    model[a] = erase ? '0 : d;
    busy_lo = k + 1;
    busy_hi = k + PC;
    cpu_a = a; cpu_din = d; {cpu_c1, cpu_c2} = erase ? 2'b01 : 2'b00;
    cpu_cs1 = 1'b1; cpu_strobe = 1'b1;
    tick();
    // Busy window: random strobes (first one a read) and short host
    // requests that are dropped before the array is free again.
    for (int i = 0; i < PC; i++) begin
      cpu_strobe = (i == 0) || ($urandom_range(0, 2) == 0);
      {cpu_c1, cpu_c2} = (i == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      cpu_a = AW'($urandom); cpu_din = DW'($urandom);
      host_a = AW'($urandom); host_rd = ($urandom_range(0, 3) == 0);
      dirty_clr = clr_at_commit && (i == PC - 1);
      tick();
    end
    cpu_strobe = 1'b0; host_rd = 1'b0; dirty_clr = 1'b0;
    exp_dirty = 1'b1;
    chk("dirty_after_commit", 32'(dirty), 1);
  endtask

  task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit both, input bit collide, input logic [AW-1:0] ca);
    int k, t;
    host_exp_t h;
    cpu_exp_t  c;
    k = cyc;
    if (collide) begin
      c.due = k + 1; c.val = model[ca]; cpu_q.push_back(c);
      cpu_a = ca; {cpu_c1, cpu_c2} = 2'b10; cpu_cs1 = 1'b1; cpu_strobe = 1'b1;
    end
    h.due = collide ? k + 2 : k + 1;
    h.rd  = !we;
    h.val = model[a];
    host_q.push_back(h);
    if (we) model[a] = d;
    host_a = a; host_din = d; host_we = we; host_rd = !we || both;
    tick();
    cpu_strobe = 1'b0;
    t = 0;
    while (!host_ack && t < 8) begin
      tick();
      t++;
    end
    if (!host_ack) chk("host_ack_timeout", 32'(host_ack), 1);
    host_rd = 1'b0; host_we = 1'b0;
    tick();
    if (we) chk("dirty_after_host_write", 32'(dirty), 32'(exp_dirty));
  endtask

  task automatic clr_dirty();
    dirty_clr = 1'b1;
    tick();
    dirty_clr = 1'b0;
    exp_dirty = 1'b0;
    chk("dirty_after_clr", 32'(dirty), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r;

    // Reset values
    tick(); tick();
    chk("rst_cpu_busy", 32'(cpu_busy), 0);
    chk("rst_cpu_dout", 32'(cpu_dout), 0);
    chk("rst_host_dout", 32'(host_dout), 0);
    chk("rst_host_ack", 32'(host_ack), 0);
    chk("rst_dirty", 32'(dirty), 0);
    reset_n = 1'b1;
    cpu_cs1 = 1'b1;
    tick();
    mon_en = 1'b1;

    // Load every cell through the host port; dirty must stay clear.
    for (int i = 0; i < DEPTH; i++)
      host_op(1'b1, AW'(i), DW'($urandom), 1'b0, 1'b0, '0);
    chk("dirty_after_load", 32'(dirty), 0);

    // Write 0xA5 to 0x12, read it back.
    cpu_write(6'h12, 8'hA5, 1'b0, 1'b0);
    cpu_read(6'h12);
    tick();

    // Host read collides with a CPU read: CPU first, then the ack.
    host_op(1'b0, 6'h12, '0, 1'b0, 1'b1, 6'h12);

    // Erase 0x12 (with an ignored read during busy), read back 0.
    cpu_write(6'h12, 8'h77, 1'b1, 1'b0);
    cpu_read(6'h12);
    tick();

    // Host write (with host_rd also set), CPU sees it, dirty untouched.
    clr_dirty();
    host_op(1'b1, 6'h3F, 8'h3C, 1'b1, 1'b0, '0);
    cpu_read(6'h3F);
    tick();
    chk("dirty_after_host_path", 32'(dirty), 0);

    // Clear arriving in the commit cycle loses to the commit.
    cpu_write(6'h20, 8'h11, 1'b0, 1'b1);
    clr_dirty();

    // NOP and deselected strobes do nothing.
    cpu_noeffect(1'b1);
    cpu_noeffect(1'b0);
    cpu_read(6'h20);
    tick();

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    cpu_write(AW'($urandom), DW'($urandom), 1'b0, 1'b0);
        2:       cpu_write(AW'($urandom), DW'($urandom), 1'b1, 1'b0);
        3, 4:    cpu_read(AW'($urandom));
        5:       cpu_noeffect($urandom_range(0, 1) == 1);
        6:       host_op(1'b0, AW'($urandom), '0, 1'b0, $urandom_range(0, 1) == 1, AW'($urandom));
        7:       host_op(1'b1, AW'($urandom), DW'($urandom), $urandom_range(0, 1) == 1, 1'b0, '0);
        8:       clr_dirty();
        default: tick();
      endcase
    end

    // Reset on busy cycle 8 of a write of 0xFF to 0x01.
    cpu_write(6'h01, 8'h5A, 1'b0, 1'b0);
    k = cyc;
    busy_lo = k + 1;
    busy_hi = k + PC;
    cpu_a = 6'h01; cpu_din = 8'hFF; {cpu_c1, cpu_c2} = 2'b00; cpu_cs1 = 1'b1; cpu_strobe = 1'b1;
    tick();
    cpu_strobe = 1'b0;
    while (cyc < k + 8) tick();
    chk("busy_before_reset", 32'(cpu_busy), 1);
    busy_hi = cyc - 1;
    reset_n = 1'b0;
    #1;
    chk("reset_busy", 32'(cpu_busy), 0);
    chk("reset_cpu_dout", 32'(cpu_dout), 0);
    chk("reset_dirty", 32'(dirty), 0);
    tick();
    reset_n = 1'b1;
    exp_dirty = 1'b0;
    repeat (PC + 2) tick();
    chk("dirty_after_abort", 32'(dirty), 0);
    cpu_read(6'h01);
    tick();
    cpu_read(AW'($urandom));
    repeat (3) tick();

    chk("host_q_drained", 32'(host_q.size()), 0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
